// File: rtl/ap_com_tt_reader.sv
// Truth-table reader for one approximate-compressor cell: sweeps every input vector,
// captures the cell output and compares it against an expected table.
module ap_com_tt_reader #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1,
  localparam int unsigned D     = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [D-1:0]    ref_tt,
  input  logic            cell_y,
  output logic [N_IN-1:0] cell_in,
  output logic            busy,
  output logic            done,
  output logic [D-1:0]    tt_out,
  output logic [D-1:0]    err_mask,
  output logic [N_IN:0]   err_cnt,
  output logic            pass
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  localparam logic [3:0]  SettleLast = 4'(SETTLE - 1);
  localparam logic [N_IN:0] IdxLast  = (N_IN + 1)'(D - 1);

  state_e            state_q, state_d;
  logic [N_IN:0]     idx_q, idx_d;
  logic [3:0]        scnt_q, scnt_d;
  logic [D-1:0]      ref_q, ref_d;
  logic [D-1:0]      tt_q, tt_d;
  logic [D-1:0]      mask_q, mask_d;
  logic [N_IN:0]     cnt_q, cnt_d;
  logic              pass_q, pass_d;

  logic [N_IN-1:0]   idx_lo;
  logic              mis;

  // idx is one bit wider than needed so the last-entry compare never sees a wrapped value.
  assign idx_lo = idx_q[N_IN-1:0];
  assign mis    = cell_y ^ ref_q[idx_lo];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    ref_d   = ref_q;
    tt_d    = tt_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ref_d   = ref_tt;
          tt_d    = '0;
          mask_d  = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          scnt_d  = '0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (scnt_q == SettleLast) begin
          tt_d[idx_lo]   = cell_y;
          mask_d[idx_lo] = mis;
          cnt_d          = cnt_q + {N_IN'(0), mis};
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end else begin
            idx_d  = idx_q + (N_IN + 1)'(1);
            scnt_d = '0;
          end
        end else begin
          scnt_d = scnt_q + 4'd1;
        end
      end
      StDone: begin
        pass_d  = (cnt_q == '0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      scnt_q  <= '0;
      ref_q   <= '0;
      tt_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      ref_q   <= ref_d;
      tt_q    <= tt_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  // cell_in follows idx, so it keeps D-1 after a sweep until the next start or reset.
  assign cell_in  = idx_lo;
  assign busy     = (state_q == StDrive);
  assign done     = (state_q == StDone);
  assign tt_out   = tt_q;
  assign err_mask = mask_q;
  assign err_cnt  = cnt_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_ap_com_tt_reader.sv
// Randomized self-checking bench: one 4-input/SETTLE=1 reader and one 3-input/SETTLE=3 reader,
// each driving a behavioural cell and checked against a cycle-level table model.
module tb_ap_com_tt_reader;

  localparam int N_IN = 4;
  localparam int S    = 1;
  localparam int D    = 16;
  localparam int TOT  = D * S + 1;   // done cycle index
  localparam int D3   = 8;
  localparam int S3   = 3;
  localparam int TOT3 = D3 * S3 + 1;

  logic clk, rst_n;
  logic start, cell_y;
  logic [15:0] ref_tt, tt_out, err_mask;
  logic [3:0]  cell_in;
  logic [4:0]  err_cnt;
  logic        busy, done, pass;

  logic start3, cell_y3;
  logic [7:0] ref3, tt3, mask3;
  logic [2:0] cell_in3;
  logic [3:0] cnt3;
  logic       busy3, done3, pass3;

  int          mode;      // 0 xor, 1 tied 0, 2 tied 1, 3 arbitrary table
  logic [15:0] cell_tt;
  logic [7:0]  cell3_tt;
  int vectors, miscompares;

  ap_com_tt_reader #(.N_IN(N_IN), .SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ref_tt(ref_tt), .cell_y(cell_y),
    .cell_in(cell_in), .busy(busy), .done(done), .tt_out(tt_out), .err_mask(err_mask),
    .err_cnt(err_cnt), .pass(pass)
  );

  ap_com_tt_reader #(.N_IN(3), .SETTLE(S3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ref_tt(ref3), .cell_y(cell_y3),
    .cell_in(cell_in3), .busy(busy3), .done(done3), .tt_out(tt3), .err_mask(mask3),
    .err_cnt(cnt3), .pass(pass3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    cell_y = 1'b0;
    case (mode)
      0: cell_y = ^cell_in;
      1: cell_y = 1'b0;
      2: cell_y = 1'b1;
      default: cell_y = cell_tt[cell_in];
    endcase
    cell_y3 = cell3_tt[cell_in3];
  end

  function automatic logic [15:0] model_tt();
    logic [15:0] t;
    for (int i = 0; i < D; i++) begin
      case (mode)
        0: t[i] = ($countones(i) % 2) == 1;
        1: t[i] = 1'b0;
        2: t[i] = 1'b1;
        default: t[i] = cell_tt[i];
      endcase
    end
    return t;
  endfunction

  // Sweep on the 4-input reader. Cycle k is Ck after the start edge E0.
  task automatic run_sweep(input logic [15:0] r, input bit disturb, input bit pulse_done,
                           input bit chain, input logic [15:0] next_r, input bit prestarted);
    logic [15:0] exp_tt, msk, e_tt, e_mask;
    logic [3:0]  e_in;
    int n, e_cnt, fin_cnt;
    exp_tt  = model_tt();
    fin_cnt = $countones(exp_tt ^ r);
    if (!prestarted) begin
      @(posedge clk); #1;
      start  = 1'b1;
      ref_tt = r;
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int k = 1; k <= TOT + 1; k++) begin
      if (disturb && k == 5) start = 1'b1;
      if (disturb && k == 6) begin start = 1'b0; ref_tt = 16'h0000; end
      if (pulse_done && k == TOT) start = 1'b1;
      if (pulse_done && k == TOT + 1) begin
        start = chain;
        if (chain) ref_tt = next_r;
      end
      @(negedge clk);
      n = (k - 1) / S;
      if (n > D) n = D;
      msk    = (n >= D) ? 16'hFFFF : 16'((32'd1 << n) - 1);
      e_tt   = exp_tt & msk;
      e_mask = (exp_tt ^ r) & msk;
      e_cnt  = $countones(e_mask);
      e_in   = (k <= D * S) ? 4'((k - 1) / S) : 4'(D - 1);
      vectors += 7;
      if (busy !== (k <= D * S)) begin
        miscompares++; $display("FAIL busy C%0d got %b want %b", k, busy, k <= D * S);
      end
      if (done !== (k == TOT)) begin
        miscompares++; $display("FAIL done C%0d got %b want %b", k, done, k == TOT);
      end
      if (cell_in !== e_in) begin
        miscompares++; $display("FAIL cell_in C%0d got %h want %h", k, cell_in, e_in);
      end
      if (tt_out !== e_tt) begin
        miscompares++; $display("FAIL tt_out C%0d got %h want %h", k, tt_out, e_tt);
      end
      if (err_mask !== e_mask) begin
        miscompares++; $display("FAIL err_mask C%0d got %h want %h", k, err_mask, e_mask);
      end
      if (err_cnt !== 5'(e_cnt)) begin
        miscompares++; $display("FAIL err_cnt C%0d got %0d want %0d", k, err_cnt, e_cnt);
      end
      if (pass !== ((k == TOT + 1) && fin_cnt == 0)) begin
        miscompares++;
        $display("FAIL pass C%0d got %b want %b", k, pass, (k == TOT + 1) && fin_cnt == 0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors += 2;
    if ({cell_in, busy, done, tt_out, err_mask, err_cnt, pass} !== '0) begin
      miscompares++;
      $display("FAIL reset_a got %h want 0",
               {cell_in, busy, done, tt_out, err_mask, err_cnt, pass});
    end
    if ({cell_in3, busy3, done3, tt3, mask3, cnt3, pass3} !== '0) begin
      miscompares++;
      $display("FAIL reset_b got %h want 0", {cell_in3, busy3, done3, tt3, mask3, cnt3, pass3});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_xor();
    mode = 0;
    run_sweep(16'h6996, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_tied();
    mode = 1;
    run_sweep(16'h6996, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    mode = 2;
    run_sweep(16'h6996, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] r;
    mode = 3;
    for (int t = 0; t < 6; t++) begin
      cell_tt = 16'($urandom);
      r = ($urandom_range(0, 1) == 1) ? cell_tt : 16'($urandom);
      run_sweep(r, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    end
  endtask

  task automatic test_ignored_inputs();
    mode = 0;
    run_sweep(16'h6996, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] r2;
    mode    = 3;
    cell_tt = 16'($urandom);
    r2      = 16'($urandom);
    // start in the done cycle is dropped; start in the following cycle chains a new sweep
    run_sweep(cell_tt, 1'b0, 1'b1, 1'b1, r2, 1'b0);
    run_sweep(r2, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    mode = 0;
    @(posedge clk); #1;
    start  = 1'b1;
    ref_tt = 16'h6996;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;   // inside C9
    #1;
    vectors++;
    if ({cell_in, busy, done, tt_out, err_mask, err_cnt, pass} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid got %h want 0",
               {cell_in, busy, done, tt_out, err_mask, err_cnt, pass});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++; $display("FAIL no_resume cyc%0d got %b%b want 00", k, busy, done);
      end
    end
    @(posedge clk); #1;
    run_sweep(16'h6996, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_settle3(input logic [7:0] ctt, input logic [7:0] r);
    logic [2:0] e_in;
    int e_cnt;
    cell3_tt = ctt;
    e_cnt    = $countones(ctt ^ r);
    @(posedge clk); #1;
    start3 = 1'b1;
    ref3   = r;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int k = 1; k <= TOT3 + 1; k++) begin
      @(negedge clk);
      e_in = (k <= D3 * S3) ? 3'((k - 1) / S3) : 3'(D3 - 1);
      vectors += 3;
      if (cell_in3 !== e_in) begin
        miscompares++; $display("FAIL s3_cell_in C%0d got %h want %h", k, cell_in3, e_in);
      end
      if (busy3 !== (k <= D3 * S3)) begin
        miscompares++; $display("FAIL s3_busy C%0d got %b want %b", k, busy3, k <= D3 * S3);
      end
      if (done3 !== (k == TOT3)) begin
        miscompares++; $display("FAIL s3_done C%0d got %b want %b", k, done3, k == TOT3);
      end
      if (k == TOT3 + 1) begin
        vectors += 4;
        if (tt3 !== ctt) begin
          miscompares++; $display("FAIL s3_tt got %h want %h", tt3, ctt);
        end
        if (mask3 !== (ctt ^ r)) begin
          miscompares++; $display("FAIL s3_mask got %h want %h", mask3, ctt ^ r);
        end
        if (cnt3 !== 4'(e_cnt)) begin
          miscompares++; $display("FAIL s3_cnt got %0d want %0d", cnt3, e_cnt);
        end
        if (pass3 !== (e_cnt == 0)) begin
          miscompares++; $display("FAIL s3_pass got %b want %b", pass3, e_cnt == 0);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_settle();
    logic [7:0] a_nb;
    for (int i = 0; i < D3; i++) a_nb[i] = ((i >> 2) & 1) == 1 && ((i >> 1) & 1) == 0;
    test_settle3(a_nb, 8'h30);
    test_settle3(8'($urandom), 8'($urandom));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    start3   = 1'b0;
    ref_tt   = '0;
    ref3     = '0;
    mode     = 0;
    cell_tt  = '0;
    cell3_tt = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_xor();
    test_tied();
    test_random();
    test_ignored_inputs();
    test_back_to_back();
    test_reset_mid();
    test_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
